// File: rtl/alu_pkg.sv
// Shared opcode and function-select definitions for the ALU bit slice.
package alu_pkg;

    // Named operation codes: [3]=a_invert, [2]=b_invert, [1:0]=function select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Function select carried in alu_op[1:0]
    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_SUM  = 2'b10,
        FN_LESS = 2'b11
    } fn_e;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder used by the ALU bit slice.
module full_adder_1b (
    input  logic aa,
    input  logic bb,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the conditioned operands
    always_comb begin
        sum  = aa ^ bb ^ cin;
        cout = (aa & bb) | (aa & cin) | (bb & cin);
    end

endmodule

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice with registered result, carry and (MSB only) overflow.
// carry_out_comb and set are left combinational so slices can ripple in one cycle.
module alu_bit_slice
    import alu_pkg::*;
#(
    parameter bit IS_MSB = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       less,
    input  logic [3:0] alu_op,
    output logic       result,
    output logic       carry_out,
    output logic       carry_out_comb,
    output logic       set,
    output logic       overflow
);

    logic aa;
    logic bb;
    logic sum;
    logic cout;
    logic result_d;
    logic overflow_d;

    // Operand conditioning from the invert bits of the opcode
    always_comb begin
        aa = a ^ alu_op[3];
        bb = b ^ alu_op[2];
    end

    full_adder_1b u_full_adder (
        .aa   (aa),
        .bb   (bb),
        .cin  (carry_in),
        .sum  (sum),
        .cout (cout)
    );

    // Function select mux and overflow next-state; all 16 opcodes are defined
    always_comb begin
        result_d = 1'b0;
        unique case (fn_e'(alu_op[1:0]))
            FN_AND:  result_d = aa & bb;
            FN_OR:   result_d = aa | bb;
            FN_SUM:  result_d = sum;
            FN_LESS: result_d = less;
            default: result_d = 1'b0;
        endcase
        // Signed overflow is carry into the MSB differing from carry out of it
        overflow_d = IS_MSB ? (carry_in ^ cout) : 1'b0;
    end

    // Ripple outputs stay live regardless of reset or function select
    always_comb begin
        carry_out_comb = cout;
        set            = sum;
    end

    // Output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            result    <= result_d;
            carry_out <= cout;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu_bit_slice.sv
// Self-checking bench for alu_bit_slice: directed plan plus randomized stimulus
// checked against an arithmetic reference model. Two instances (MSB and non-MSB)
// share the same stimulus.
module tb_alu_bit_slice;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       carry_in;
    logic       less;
    logic [3:0] alu_op;

    logic result_m, carry_out_m, carry_out_comb_m, set_m, overflow_m;
    logic result_l, carry_out_l, carry_out_comb_l, set_l, overflow_l;

    int checks;
    int errors;

    alu_bit_slice #(.IS_MSB(1'b1)) dut_msb (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .carry_in       (carry_in),
        .less           (less),
        .alu_op         (alu_op),
        .result         (result_m),
        .carry_out      (carry_out_m),
        .carry_out_comb (carry_out_comb_m),
        .set            (set_m),
        .overflow       (overflow_m)
    );

    alu_bit_slice #(.IS_MSB(1'b0)) dut_lsb (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .carry_in       (carry_in),
        .less           (less),
        .alu_op         (alu_op),
        .result         (result_l),
        .carry_out      (carry_out_l),
        .carry_out_comb (carry_out_comb_l),
        .set            (set_l),
        .overflow       (overflow_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic on the conditioned operands.
    // Returns {sum, cout, result, overflow_if_msb}.
    function automatic logic [3:0] model(input logic ma, input logic mb, input logic mc,
                                         input logic ml, input logic [3:0] op);
        int ia, ib, total, res;
        logic s, co;
        ia    = op[3] ? 1 - int'(ma) : int'(ma);
        ib    = op[2] ? 1 - int'(mb) : int'(mb);
        total = ia + ib + int'(mc);
        s     = (total % 2) == 1;
        co    = total >= 2;
        case (op[1:0])
            2'd0:    res = ia * ib;
            2'd1:    res = (ia + ib > 0) ? 1 : 0;
            2'd2:    res = total % 2;
            default: res = int'(ml);
        endcase
        return {s, co, res[0], mc != co};
    endfunction

    // Drive one cycle of stimulus, check combinational outputs, then registered ones
    task automatic apply(input logic r, input logic ta, input logic tb_, input logic tc,
                         input logic tl, input logic [3:0] op, input string tag);
        logic [3:0] m;
        rst      = r;
        a        = ta;
        b        = tb_;
        carry_in = tc;
        less     = tl;
        alu_op   = op;
        m = model(ta, tb_, tc, tl, op);
        #1;
        check_bit({tag, ".set"},      set_m,            m[3]);
        check_bit({tag, ".cout_comb"}, carry_out_comb_m, m[2]);
        check_bit({tag, ".set_l"},    set_l,            m[3]);
        @(posedge clk);
        #1;
        check_bit({tag, ".result"},   result_m,    r ? 1'b0 : m[1]);
        check_bit({tag, ".carry_out"}, carry_out_m, r ? 1'b0 : m[2]);
        check_bit({tag, ".overflow"}, overflow_m,  r ? 1'b0 : m[0]);
        check_bit({tag, ".result_l"}, result_l,    r ? 1'b0 : m[1]);
        check_bit({tag, ".carry_l"},  carry_out_l, r ? 1'b0 : m[2]);
        check_bit({tag, ".ovf_l"},    overflow_l,  1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; a = 1'b0; b = 1'b0; carry_in = 1'b0; less = 1'b0; alu_op = ALU_AND;
        @(posedge clk);
        #1;

        // Reset held with inputs that would otherwise produce ones
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD, "rst0");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD, "rst1");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD, "rst_release");
        // Explicit constants from the plan for the release cycle
        check_bit("release.result_const", result_m, 1'b1);
        check_bit("release.carry_const", carry_out_m, 1'b1);

        // AND / OR sweep
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND, "and00");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_AND, "and10");
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALU_AND, "and11");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_AND, "and01");
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OR,  "or00");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OR,  "or10");
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OR,  "or11");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_OR,  "or01");

        // ADD exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            apply(1'b0, v[2], v[1], v[0], 1'b0, ALU_ADD, $sformatf("add%0d", i));
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD, "add111");
        check_bit("add111.result_const", result_m, 1'b1);
        check_bit("add111.carry_const", carry_out_m, 1'b1);

        // SUB with carry_in tied high
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ALU_SUB, "sub11");
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_SUB, "sub01");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_SUB, "sub10");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SUB, "sub00");
        check_bit("sub00.no_borrow", carry_out_m, 1'b1);

        // NOR and SLT
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_NOR, "nor00");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_NOR, "nor10");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_SLT, "slt_less1");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SLT, "slt_less0");
        check_bit("slt.set_const", set_m, 1'b0);

        // Overflow cases on the MSB
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD, "ovf001");
        check_bit("ovf001.const", overflow_m, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD, "ovf110");
        check_bit("ovf110.const", overflow_m, 1'b1);
        apply(1'b0, 1'b1, 0, 1'b1, 1'b0, ALU_ADD, "ovf101");
        check_bit("ovf101.const", overflow_m, 1'b0);

        // Mid-stream reset
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101, "pre_rst");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ALU_ADD, "mid_rst");

        // Randomized stimulus across all 16 opcodes with occasional reset
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
